// File: rtl/el2_lsu_clkgate_sched.sv
// el2_lsu_clkgate_sched: idle-hysteresis scheduler for the LSU free clock (clken, wake stall, halt ack, gated-cycle telemetry)
module el2_lsu_clkgate_sched #(
  parameter int IDLE_CYC = 8,
  parameter int WAKE_CYC = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_override,
  input  logic            lsu_act_any,
  input  logic            lsu_wake_req,
  input  logic            lsu_bus_buffer_empty_any,
  input  logic            lsu_stbuf_empty_any,
  input  logic            lsu_halt_req,
  input  logic            lsu_gated_cnt_clr,
  output logic            lsu_free_clken,
  output logic            lsu_wake_stall,
  output logic            lsu_halt_ack,
  output logic [1:0]      lsu_gate_state,
  output logic [CNTW-1:0] lsu_gated_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, HYST = 2'd1, GATED = 2'd2, WAKE = 2'd3} state_t;
  localparam logic [7:0] IDLE_LD = 8'(IDLE_CYC - 1);
  localparam logic [7:0] WAKE_LD = 8'((WAKE_CYC == 0) ? 0 : WAKE_CYC - 1);
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic idle, wake;
  assign idle = ~lsu_act_any & ~lsu_wake_req & lsu_bus_buffer_empty_any & lsu_stbuf_empty_any;
  assign wake = lsu_act_any | lsu_wake_req | ~lsu_bus_buffer_empty_any | ~lsu_stbuf_empty_any;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      RUN: if (idle) begin
        state_nxt = lsu_halt_req ? GATED : HYST;
        cnt_nxt = IDLE_LD;
      end
      HYST: if (!idle) state_nxt = RUN;
        else if (lsu_halt_req || cnt == 8'd0) state_nxt = GATED;
        else cnt_nxt = cnt - 8'd1;
      GATED: if (wake) begin
        state_nxt = (WAKE_CYC == 0) ? RUN : WAKE;
        cnt_nxt = WAKE_LD;
      end
      WAKE: if (cnt == 8'd0) state_nxt = RUN;
        else cnt_nxt = cnt - 8'd1;
      default: state_nxt = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= 8'd0;
      lsu_halt_ack <= 1'b0;
      lsu_gated_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      // idle and wake are complementary, so "set on halt&idle, clear on ~halt or wake" collapses to this
      lsu_halt_ack <= lsu_halt_req & idle;
      lsu_gated_cnt <= lsu_gated_cnt_clr ? '0 :
                       (state == GATED && !clk_override && !(&lsu_gated_cnt)) ? lsu_gated_cnt + CNTW'(1) :
                       lsu_gated_cnt;
    end
  end
  assign lsu_gate_state = state;
  assign lsu_free_clken = (state != GATED) | clk_override;
  assign lsu_wake_stall = (state == WAKE);
endmodule

// File: tb/tb_el2_lsu_clkgate_sched.sv
// tb_el2_lsu_clkgate_sched: directed scoreboard bench for el2_lsu_clkgate_sched (default instance plus a short-window, 4-bit-counter instance)
module tb_el2_lsu_clkgate_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic ovr, act, wreq, bbe, sbe, halt, clr;
  logic a_clken, a_stall, a_ack, b_clken, b_stall, b_ack;
  logic [1:0] a_st, b_st;
  logic [15:0] a_cnt;
  logic [3:0] b_cnt;
  always #5 clk = ~clk;
  el2_lsu_clkgate_sched dut_a (
    .clk(clk), .rst(rst), .clk_override(ovr), .lsu_act_any(act), .lsu_wake_req(wreq),
    .lsu_bus_buffer_empty_any(bbe), .lsu_stbuf_empty_any(sbe), .lsu_halt_req(halt),
    .lsu_gated_cnt_clr(clr), .lsu_free_clken(a_clken), .lsu_wake_stall(a_stall),
    .lsu_halt_ack(a_ack), .lsu_gate_state(a_st), .lsu_gated_cnt(a_cnt));
  el2_lsu_clkgate_sched #(.IDLE_CYC(1), .WAKE_CYC(0), .CNTW(4)) dut_b (
    .clk(clk), .rst(rst), .clk_override(ovr), .lsu_act_any(act), .lsu_wake_req(wreq),
    .lsu_bus_buffer_empty_any(bbe), .lsu_stbuf_empty_any(sbe), .lsu_halt_req(halt),
    .lsu_gated_cnt_clr(clr), .lsu_free_clken(b_clken), .lsu_wake_stall(b_stall),
    .lsu_halt_ack(b_ack), .lsu_gate_state(b_st), .lsu_gated_cnt(b_cnt));
  // input vector bits: {act, wake_req, bus_empty, stbuf_empty, halt, override, clr}
  localparam logic [6:0] I_IDLE = 7'b0011000;
  localparam logic [6:0] I_ACT  = 7'b1011000;
  localparam logic [6:0] I_WREQ = 7'b0111000;
  localparam logic [6:0] I_HALT = 7'b0011100;
  localparam logic [6:0] I_OVR  = 7'b0011010;
  localparam logic [6:0] I_CLR  = 7'b0000001;
  typedef struct {
    bit sel;
    logic [1:0] st;
    logic clken, stall, ack;
    int cnt;
    string tag;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  function automatic void cmp(string tag, string field, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s.%s got %0d expected %0d", tag, field, got, want);
    end
  endfunction
  task automatic step(input logic [6:0] iv, input bit sel, input logic [1:0] st, input logic ack, input int cnt, input string tag);
    {act, wreq, bbe, sbe, halt, ovr, clr} = iv;
    q.push_back('{sel, st, (st != 2'd2) | iv[1], st == 2'd3, ack, cnt, tag});
    @(negedge clk);
  endtask
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          cmp(e.tag, "state", 32'(a_st), 32'(e.st));
          cmp(e.tag, "clken", 32'(a_clken), 32'(e.clken));
          cmp(e.tag, "stall", 32'(a_stall), 32'(e.stall));
          cmp(e.tag, "ack", 32'(a_ack), 32'(e.ack));
          cmp(e.tag, "cnt", 32'(a_cnt), 32'(e.cnt));
        end else begin
          cmp(e.tag, "state", 32'(b_st), 32'(e.st));
          cmp(e.tag, "clken", 32'(b_clken), 32'(e.clken));
          cmp(e.tag, "stall", 32'(b_stall), 32'(e.stall));
          cmp(e.tag, "ack", 32'(b_ack), 32'(e.ack));
          cmp(e.tag, "cnt", 32'(b_cnt), 32'(e.cnt));
        end
      end
    end
  end
  initial begin
    {act, wreq, bbe, sbe, halt, ovr, clr} = I_IDLE;
    #2;
    cmp("reset_a", "state", 32'(a_st), 0);
    cmp("reset_a", "clken", 32'(a_clken), 1);
    cmp("reset_a", "stall", 32'(a_stall), 0);
    cmp("reset_a", "ack", 32'(a_ack), 0);
    cmp("reset_a", "cnt", 32'(a_cnt), 0);
    cmp("reset_b", "state", 32'(b_st), 0);
    cmp("reset_b", "cnt", 32'(b_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) step(I_IDLE, 0, 2'd1, 0, 0, "t1_hyst");
    step(I_IDLE, 0, 2'd2, 0, 0, "t1_gated");
    for (int k = 1; k <= 3; k++) step(I_IDLE, 0, 2'd2, 0, k, "t1_cnt");
    step(I_WREQ, 0, 2'd3, 0, 4, "t3_wake");
    step(I_IDLE, 0, 2'd3, 0, 4, "t3_wake2");
    step(I_IDLE, 0, 2'd0, 0, 4, "t3_run");
    step(I_ACT | I_CLR, 0, 2'd0, 0, 0, "clr");
    for (int k = 1; k <= 5; k++) step(I_IDLE, 0, 2'd1, 0, 0, "t2_hyst");
    step(I_ACT, 0, 2'd0, 0, 0, "t2_run");
    for (int k = 1; k <= 5; k++) step(7'b0010100, 0, 2'd0, 0, 0, "t4_busy");
    step(I_HALT, 0, 2'd2, 1, 0, "t4_fast");
    step(I_HALT, 0, 2'd2, 1, 1, "t4_hold");
    step(I_IDLE, 0, 2'd2, 0, 2, "t4_drop");
    step(I_IDLE, 0, 2'd2, 0, 3, "t4_stay");
    step(I_HALT, 0, 2'd2, 1, 4, "ack_set");
    step(7'b1011100, 0, 2'd3, 0, 5, "ack_wake");
    step(I_IDLE, 0, 2'd3, 0, 5, "ack_wake2");
    step(I_IDLE, 0, 2'd0, 0, 5, "ack_run");
    step(I_HALT, 0, 2'd2, 1, 5, "t5_gate");
    step(I_IDLE, 0, 2'd2, 0, 6, "t5_gated");
    for (int k = 1; k <= 10; k++) step(I_OVR, 0, 2'd2, 0, 6, "t5_ovr");
    step(I_IDLE, 0, 2'd2, 0, 7, "t5_resume");
    step(I_IDLE, 0, 2'd2, 0, 8, "t5_resume2");
    step(7'b0001000, 0, 2'd3, 0, 9, "bb_wake");
    step(I_ACT, 0, 2'd3, 0, 9, "wake_ign");
    step(I_ACT, 0, 2'd0, 0, 9, "wake_done");
    step(I_IDLE, 0, 2'd1, 0, 9, "hyst1");
    step(I_IDLE, 0, 2'd1, 0, 9, "hyst2");
    step(I_HALT, 0, 2'd2, 1, 9, "hyst_fast");
    step(I_ACT, 0, 2'd3, 0, 10, "pre_rst_wake");
    #2;
    rst = 1'b1;
    #1;
    cmp("async_rst", "state", 32'(a_st), 0);
    cmp("async_rst", "clken", 32'(a_clken), 1);
    cmp("async_rst", "stall", 32'(a_stall), 0);
    cmp("async_rst", "cnt", 32'(a_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    step(I_IDLE, 1, 2'd1, 0, 0, "b_hyst");
    step(I_IDLE, 1, 2'd2, 0, 0, "b_gated");
    for (int k = 1; k <= 20; k++) step(I_IDLE, 1, 2'd2, 0, (k > 15) ? 15 : k, "b_sat");
    step(I_IDLE | I_CLR, 1, 2'd2, 0, 0, "b_clr");
    step(I_IDLE, 1, 2'd2, 0, 1, "b_inc1");
    step(I_IDLE, 1, 2'd2, 0, 2, "b_inc2");
    step(I_WREQ, 1, 2'd0, 0, 3, "b_wake0");
    step(I_ACT, 1, 2'd0, 0, 3, "b_run");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
